// File: rtl/ann_class_decoder.sv
// ann_class_decoder: picks the class with the largest |score| from four signed
// scores, scanning one element per cycle. It reports the winning index and
// the margin to the runner-up, and it tracks how many consecutive confident
// results agree on the same class.
module ann_class_decoder #(
  parameter int W            = 16,
  parameter int MIN_MARGIN   = 16,
  parameter int STABLE_COUNT = 3
) (
  input  logic                clk,
  input  logic                rst_n,
  input  logic                in_valid,
  output logic                in_ready,
  input  logic signed [W-1:0] o0,
  input  logic signed [W-1:0] o1,
  input  logic signed [W-1:0] o2,
  input  logic signed [W-1:0] o3,
  output logic                out_valid,
  input  logic                out_ready,
  output logic [1:0]          pred_class,
  output logic [W-1:0]        margin,
  output logic                low_conf,
  output logic                stable,
  output logic [1:0]          stable_class
);

  localparam logic [W-1:0]        ABS_MAX  = {1'b0, {(W-1){1'b1}}};
  localparam logic signed [W-1:0] NEG_MIN  = {1'b1, {(W-1){1'b0}}};
  localparam logic [W-1:0]        MIN_M    = W'(MIN_MARGIN);
  localparam logic [3:0]          STABLE_N = 4'(STABLE_COUNT);

  typedef enum logic [1:0] {S_IDLE, S_SCAN, S_DONE} state_t;

  state_t r_state, w_state_nxt;

  logic [3:0][W-1:0] r_buf;
  logic [W-1:0]      r_max_abs, r_sec_abs;
  logic [1:0]        r_best_idx, r_idx;
  logic [1:0]        r_pred;
  logic [W-1:0]      r_margin;
  logic              r_low_conf;
  logic [3:0]        r_cnt;
  logic              r_stable;
  logic [1:0]        r_stable_class;

  logic                w_accept, w_out_hs;
  logic signed [W-1:0] w_elem;
  logic [W-1:0]        w_abs, w_max_nxt, w_sec_nxt, w_margin_nxt;
  logic [1:0]          w_best_nxt;
  logic [3:0]          w_cnt_nxt;
  logic [1:0]          w_sc_nxt;

  assign in_ready     = (r_state == S_IDLE);
  assign out_valid    = (r_state == S_DONE);
  assign w_accept     = in_valid && in_ready;
  assign w_out_hs     = out_valid && out_ready;
  assign pred_class   = r_pred;
  assign margin       = r_margin;
  assign low_conf     = r_low_conf;
  assign stable       = r_stable;
  assign stable_class = r_stable_class;

  // State register.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) r_state <= S_IDLE;
    else        r_state <= w_state_nxt;
  end

  // Next-state: accept, four scan cycles, then hold until the result is taken.
  always_comb begin
    w_state_nxt = r_state;
    case (r_state)
      S_IDLE:  if (in_valid)        w_state_nxt = S_SCAN;
      S_SCAN:  if (r_idx == 2'd3)   w_state_nxt = S_DONE;
      S_DONE:  if (out_ready)       w_state_nxt = S_IDLE;
      default:                      w_state_nxt = S_IDLE;
    endcase
  end

  // One scan step: saturating abs of the current element and a top-two update.
  // Strict compares keep the earliest index on ties.
  always_comb begin
    w_elem = signed'(r_buf[r_idx]);
    if (w_elem == NEG_MIN)  w_abs = ABS_MAX;
    else if (w_elem[W-1])   w_abs = $unsigned(-w_elem);
    else                    w_abs = $unsigned(w_elem);
    w_max_nxt  = r_max_abs;
    w_sec_nxt  = r_sec_abs;
    w_best_nxt = r_best_idx;
    if (w_abs > r_max_abs) begin
      w_sec_nxt  = r_max_abs;
      w_max_nxt  = w_abs;
      w_best_nxt = r_idx;
    end else if (w_abs > r_sec_abs) begin
      w_sec_nxt = w_abs;
    end
    w_margin_nxt = w_max_nxt - w_sec_nxt;
  end

  // Capture the vector on accept, step the scan, and register the result on the last element.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_buf      <= '0;
      r_max_abs  <= '0;
      r_sec_abs  <= '0;
      r_best_idx <= 2'd0;
      r_idx      <= 2'd0;
      r_pred     <= 2'd0;
      r_margin   <= '0;
      r_low_conf <= 1'b0;
    end else if (w_accept) begin
      r_buf      <= {o3, o2, o1, o0};
      r_max_abs  <= '0;
      r_sec_abs  <= '0;
      r_best_idx <= 2'd0;
      r_idx      <= 2'd0;
    end else if (r_state == S_SCAN) begin
      r_max_abs  <= w_max_nxt;
      r_sec_abs  <= w_sec_nxt;
      r_best_idx <= w_best_nxt;
      r_idx      <= r_idx + 2'd1;
      if (r_idx == 2'd3) begin
        r_pred     <= w_best_nxt;
        r_margin   <= w_margin_nxt;
        r_low_conf <= (w_margin_nxt < MIN_M);
      end
    end
  end

  // Agreement counter: low confidence clears it, a repeated class saturates it upward,
  // and a new confident class restarts it at one.
  always_comb begin
    w_cnt_nxt = r_cnt;
    w_sc_nxt  = r_stable_class;
    if (r_low_conf) begin
      w_cnt_nxt = 4'd0;
    end else if ((r_pred == r_stable_class) && (r_cnt != 4'd0)) begin
      w_cnt_nxt = (r_cnt >= STABLE_N) ? STABLE_N : r_cnt + 4'd1;
    end else begin
      w_cnt_nxt = 4'd1;
      w_sc_nxt  = r_pred;
    end
  end

  // Stability state moves only when a result is handed downstream.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_cnt          <= 4'd0;
      r_stable       <= 1'b0;
      r_stable_class <= 2'd0;
    end else if (w_out_hs) begin
      r_cnt          <= w_cnt_nxt;
      r_stable_class <= w_sc_nxt;
      r_stable       <= (w_cnt_nxt >= STABLE_N);
    end
  end

endmodule

// File: tb/tb_ann_class_decoder.sv
// Bench for ann_class_decoder: directed cases plus randomized vectors, checked
// every cycle against a transaction-level model of the decoder.
module tb_ann_class_decoder;

  logic               clk = 1'b0;
  logic               rst_n = 1'b0;
  logic               in_valid = 1'b0;
  logic               in_ready;
  logic signed [15:0] o0 = '0, o1 = '0, o2 = '0, o3 = '0;
  logic               out_valid;
  logic               out_ready = 1'b0;
  logic [1:0]         pred_class;
  logic [15:0]        margin;
  logic               low_conf, stable;
  logic [1:0]         stable_class;

  int n_cmp = 0;
  int n_err = 0;

  ann_class_decoder #(.W(16), .MIN_MARGIN(16), .STABLE_COUNT(3)) dut (
    .clk(clk), .rst_n(rst_n), .in_valid(in_valid), .in_ready(in_ready),
    .o0(o0), .o1(o1), .o2(o2), .o3(o3),
    .out_valid(out_valid), .out_ready(out_ready),
    .pred_class(pred_class), .margin(margin), .low_conf(low_conf),
    .stable(stable), .stable_class(stable_class)
  );

  always #5 clk = ~clk;

  typedef struct packed { logic [1:0] p; logic [15:0] m; logic lc; } res_t;
  typedef struct packed { int cnt; logic st; logic [1:0] sc; } stab_t;

  // Winner = lowest index holding the largest saturated |score|;
  // margin = largest minus the largest of the remaining three.
  function automatic res_t decode(input int v0, input int v1, input int v2, input int v3);
    int a[4];
    int mx, sec, pi;
    res_t r;
    a[0] = v0; a[1] = v1; a[2] = v2; a[3] = v3;
    for (int i = 0; i < 4; i++) begin
      if (a[i] < 0) a[i] = -a[i];
      if (a[i] > 32767) a[i] = 32767;
    end
    mx = -1; pi = 0;
    for (int i = 0; i < 4; i++) if (a[i] > mx) begin mx = a[i]; pi = i; end
    sec = 0;
    for (int i = 0; i < 4; i++) if (i != pi && a[i] > sec) sec = a[i];
    r.p  = 2'(pi);
    r.m  = 16'(mx - sec);
    r.lc = ((mx - sec) < 16);
    return r;
  endfunction

  function automatic stab_t stab_upd(input stab_t s, input res_t r);
    stab_t n;
    n = s;
    if (r.lc) n.cnt = 0;
    else if (r.p == s.sc && s.cnt > 0) n.cnt = (s.cnt + 1 > 3) ? 3 : s.cnt + 1;
    else begin n.cnt = 1; n.sc = r.p; end
    n.st = (n.cnt >= 3);
    return n;
  endfunction

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got %0d expected %0d at %0t", nm, act, exp, $time);
    end
  endtask

  // Transaction-level model: idle / scanning (counts edges) / holding a result.
  int    m_state = 0;
  int    m_n = 0;
  res_t  m_res = '0;
  stab_t m_stab = '0;

  always @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      m_state <= 0; m_n <= 0; m_res <= '0; m_stab <= '0;
    end else begin
      case (m_state)
        0: if (in_valid) begin
             m_res <= decode(int'(o0), int'(o1), int'(o2), int'(o3));
             m_state <= 1; m_n <= 0;
           end
        1: begin
             m_n <= m_n + 1;
             if (m_n == 3) m_state <= 2;
           end
        default: if (out_ready) begin
             m_stab <= stab_upd(m_stab, m_res);
             m_state <= 0;
           end
      endcase
    end
  end

  // Per-cycle compare against the model.
  always @(negedge clk) begin
    if (rst_n) begin
      chk("in_ready", 32'(in_ready), 32'(m_state == 0));
      chk("out_valid", 32'(out_valid), 32'(m_state == 2));
      if (m_state == 2) begin
        chk("pred_class", 32'(pred_class), 32'(m_res.p));
        chk("margin", 32'(margin), 32'(m_res.m));
        chk("low_conf", 32'(low_conf), 32'(m_res.lc));
      end
      chk("stable", 32'(stable), 32'(m_stab.st));
      chk("stable_class", 32'(stable_class), 32'(m_stab.sc));
    end
  end

  // Present a vector at a falling edge and return at the falling edge after acceptance.
  task automatic send(input logic signed [15:0] a, input logic signed [15:0] b,
                      input logic signed [15:0] c, input logic signed [15:0] d);
    int t;
    o0 = a; o1 = b; o2 = c; o3 = d; in_valid = 1'b1;
    t = 0;
    while (!in_ready && t < 50) begin @(negedge clk); t++; end
    chk("send_timeout", 32'(in_ready), 32'd1);
    @(posedge clk);
    @(negedge clk);
    in_valid = 1'b0;
    o0 = 16'($urandom); o1 = 16'($urandom); o2 = 16'($urandom); o3 = 16'($urandom);
  endtask

  // Wait for a result, stall it for 'hold' cycles, then take it.
  task automatic get(input int hold);
    int t;
    t = 0;
    while (!out_valid && t < 50) begin @(negedge clk); t++; end
    chk("get_timeout", 32'(out_valid), 32'd1);
    repeat (hold) @(negedge clk);
    out_ready = 1'b1;
    @(negedge clk);
    out_ready = 1'b0;
  endtask

  initial begin
    #400000;
    $display("FAIL watchdog: simulation did not finish in time");
    $fatal(1, "watchdog");
  end

  initial begin
    res_t r;
    int   n;
    int   v[4];
    int   cls;
    logic signed [15:0] sat[4];

    // Reset values.
    #12;
    chk("rst_in_ready", 32'(in_ready), 32'd1);
    chk("rst_out_valid", 32'(out_valid), 32'd0);
    chk("rst_pred", 32'(pred_class), 32'd0);
    chk("rst_margin", 32'(margin), 32'd0);
    chk("rst_low_conf", 32'(low_conf), 32'd0);
    chk("rst_stable", 32'(stable), 32'd0);
    chk("rst_stable_class", 32'(stable_class), 32'd0);
    @(negedge clk); #2 rst_n = 1'b1;
    @(negedge clk);

    // Hand-computed pins on the model itself.
    r = decode(100, -300, 200, 50);
    chk("pin_basic_p", 32'(r.p), 32'd1);
    chk("pin_basic_m", 32'(r.m), 32'd100);
    r = decode(250, -250, 0, 0);
    chk("pin_tie_p", 32'(r.p), 32'd0);
    chk("pin_tie_lc", 32'(r.lc), 32'd1);
    r = decode(-32768, 32767, 0, 0);
    chk("pin_sat_m", 32'(r.m), 32'd0);

    // Basic winner and latency.
    send(16'sd100, -16'sd300, 16'sd200, 16'sd50);
    n = 0;
    while (!out_valid && n < 20) begin @(negedge clk); n++; end
    chk("latency_edges", 32'(n), 32'd4);
    chk("basic_pred", 32'(pred_class), 32'd1);
    chk("basic_margin", 32'(margin), 32'd100);
    chk("basic_low_conf", 32'(low_conf), 32'd0);
    get(0);

    // Tie and saturation.
    send(16'sd250, -16'sd250, 16'sd0, 16'sd0);
    get(0);
    chk("tie_pred", 32'(pred_class), 32'd0);
    chk("tie_margin", 32'(margin), 32'd0);
    chk("tie_low_conf", 32'(low_conf), 32'd1);
    send(-16'sd32768, 16'sd32767, 16'sd0, 16'sd0);
    get(0);
    chk("sat_pred", 32'(pred_class), 32'd0);
    chk("sat_margin", 32'(margin), 32'd0);

    // Backpressure with a second vector waiting the whole time.
    send(16'sd7, 16'sd1000, 16'sd3, 16'sd2);
    o0 = -16'sd500; o1 = 16'sd0; o2 = 16'sd0; o3 = 16'sd0; in_valid = 1'b1;
    n = 0;
    while (!out_valid && n < 20) begin @(negedge clk); n++; end
    for (int k = 0; k < 10; k++) begin
      chk("bp_in_ready", 32'(in_ready), 32'd0);
      chk("bp_pred", 32'(pred_class), 32'd1);
      chk("bp_margin", 32'(margin), 32'd993);
      chk("bp_out_valid", 32'(out_valid), 32'd1);
      @(negedge clk);
    end
    out_ready = 1'b1;
    @(negedge clk);
    out_ready = 1'b0;
    chk("bp_ov_fall", 32'(out_valid), 32'd0);
    chk("bp_in_ready_back", 32'(in_ready), 32'd1);
    @(posedge clk);
    @(negedge clk);
    in_valid = 1'b0;
    chk("bp_second_accepted", 32'(in_ready), 32'd0);
    get(0);
    chk("bp2_pred", 32'(pred_class), 32'd0);
    chk("bp2_margin", 32'(margin), 32'd500);

    // Clear the agreement counter, then build stability on class 3.
    send(16'sd1, 16'sd2, 16'sd3, 16'sd4);
    get(0);
    chk("lc_small", 32'(low_conf), 32'd1);
    for (int k = 0; k < 3; k++) begin
      send(16'sd0, 16'sd0, 16'sd10, 16'sd400);
      get(0);
      chk("stab_rise", 32'(stable), 32'(k == 2));
      chk("stab_class3", 32'(stable_class), 32'd3);
    end
    send(16'sd0, 16'sd0, 16'sd500, 16'sd10);
    get(0);
    chk("stab_switch", 32'(stable), 32'd0);
    chk("stab_class2", 32'(stable_class), 32'd2);
    send(16'sd100, 16'sd90, 16'sd0, 16'sd0);
    get(0);
    chk("stab_lc", 32'(low_conf), 32'd1);
    chk("stab_lc_stable", 32'(stable), 32'd0);
    chk("stab_lc_keep", 32'(stable_class), 32'd2);

    // Reset in the middle of a scan.
    send(16'sd10, 16'sd20, 16'sd500, 16'sd30);
    @(negedge clk);
    #2 rst_n = 1'b0;
    @(negedge clk);
    chk("rst_mid_ov", 32'(out_valid), 32'd0);
    chk("rst_mid_in_ready", 32'(in_ready), 32'd1);
    #2 rst_n = 1'b1;
    repeat (8) begin
      @(negedge clk);
      chk("rst_no_ov", 32'(out_valid), 32'd0);
    end
    chk("rst_after_in_ready", 32'(in_ready), 32'd1);
    chk("rst_after_stable", 32'(stable), 32'd0);
    send(16'sd0, 16'sd0, 16'sd0, -16'sd900);
    get(0);
    chk("rst_next_pred", 32'(pred_class), 32'd3);
    chk("rst_next_margin", 32'(margin), 32'd900);

    // Randomized vectors with random stalls.
    sat[0] = -16'sd32768; sat[1] = 16'sd32767; sat[2] = -16'sd32767; sat[3] = 16'sd0;
    for (int it = 0; it < 60; it++) begin
      case ($urandom_range(0, 3))
        0: for (int i = 0; i < 4; i++) v[i] = int'($urandom_range(0, 65535)) - 32768;
        1: for (int i = 0; i < 4; i++) v[i] = int'($urandom_range(0, 40)) - 20;
        2: begin
             cls = int'($urandom_range(2, 3));
             for (int i = 0; i < 4; i++) v[i] = int'($urandom_range(0, 600)) - 300;
             v[cls] = 1000 + int'($urandom_range(0, 500));
             if ($urandom_range(0, 1) == 1) v[cls] = -v[cls];
           end
        default: for (int i = 0; i < 4; i++) v[i] = int'(sat[$urandom_range(0, 3)]);
      endcase
      send(16'(v[0]), 16'(v[1]), 16'(v[2]), 16'(v[3]));
      get(int'($urandom_range(0, 3)));
    end

    repeat (3) @(negedge clk);
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule
